// File: rtl/hdmi_init_seq.sv
// HDMI transmitter init sequencer: walks a {reg,value} table and issues one I2C write per entry.
// Optional build macro HDMI_INIT_RETRY_EN enables up to MAX_RETRY re-attempts of a NACKed entry.
module hdmi_init_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h39,
    parameter int unsigned NUM_ENTRIES  = 32,
    parameter int unsigned POWERUP_WAIT = 1000,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clk2,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  rom_index,
    input  logic [15:0] rom_data,
    output logic        i2c_enable,
    output logic [6:0]  i2c_addr,
    output logic [15:0] i2c_data,
    input  logic        i2c_done,
    input  logic [2:0]  i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  err_index
);

    localparam int unsigned CMAX = (POWERUP_WAIT > GAP_CYCLES) ? POWERUP_WAIT : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        LOAD,
        WRITE,
        GAP,
        DONE,
        ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [6:0]    idx;      // one bit wider than rom_index so NUM_ENTRIES=64 is reachable
    logic          ok;

`ifdef HDMI_INIT_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry;
`endif

    assign rom_index = idx[5:0];
    assign i2c_addr  = DEV_ADDR;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            ok         <= 1'b0;
            i2c_enable <= 1'b0;
            i2c_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
`ifdef HDMI_INIT_RETRY_EN
            retry      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        idx       <= '0;
                        cnt       <= CW'(POWERUP_WAIT);
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        busy      <= 1'b1;
`ifdef HDMI_INIT_RETRY_EN
                        retry     <= '0;
`endif
                        state     <= PWR_WAIT;
                    end
                end
                PWR_WAIT: begin
                    if (cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                LOAD: begin
                    if (rom_data == 16'hFFFF || idx == 7'(NUM_ENTRIES)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        i2c_data   <= rom_data;
                        i2c_enable <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (i2c_done) begin
                        i2c_enable <= 1'b0;
                        ok         <= (i2c_nack == 3'b000);
                        cnt        <= CW'(GAP_CYCLES);
                        state      <= GAP;
                    end
                end
                GAP: begin
                    // Counts GAP_CYCLES..1, so exactly GAP_CYCLES cycles are spent here
                    if (cnt > CW'(1)) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        cnt <= '0;
                        if (ok) begin
                            idx   <= idx + 7'd1;
`ifdef HDMI_INIT_RETRY_EN
                            retry <= '0;
`endif
                            state <= LOAD;
`ifdef HDMI_INIT_RETRY_EN
                        end else if (retry < RW'(MAX_RETRY)) begin
                            retry      <= retry + RW'(1);
                            i2c_enable <= 1'b1;
                            state      <= WRITE;
`endif
                        end else begin
                            error     <= 1'b1;
                            err_index <= idx[5:0];
                            busy      <= 1'b0;
                            state     <= ERROR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_init_seq.sv
// Directed bench for hdmi_init_seq: table-driven sequences against a small ACK/NACK slave model.
// Expectations follow HDMI_INIT_RETRY_EN as seen by the bench build.
module tb_hdmi_init_seq;

    logic        clk2 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  rom_index;
    logic [15:0] rom_data;
    logic        i2c_enable;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic        i2c_done = 1'b0;
    logic [2:0]  i2c_nack = 3'b000;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  err_index;

    always #5 clk2 = ~clk2;

    logic [15:0] rom [64];
    int unsigned nack_left [64];
    assign rom_data = rom[rom_index];

    hdmi_init_seq #(
        .DEV_ADDR    (7'h39),
        .NUM_ENTRIES (4),
        .POWERUP_WAIT(5),
        .GAP_CYCLES  (4),
        .MAX_RETRY   (3)
    ) dut (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .start     (start),
        .rom_index (rom_index),
        .rom_data  (rom_data),
        .i2c_enable(i2c_enable),
        .i2c_addr  (i2c_addr),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave model: answers 3 cycles after enable rises, NACKs per nack_left plan
    int          s_cnt    = 0;
    int          nwr      = 0;
    int          low_cnt  = 0;
    int          min_gap  = 1000;
    int          stab_err = 0;
    int          both_err = 0;
    logic        prev_en  = 1'b0;
    logic [15:0] cur_data = '0;
    logic [15:0] wr_data [16];

    initial begin
        forever begin
            @(negedge clk2);
            if (done && error) both_err++;
            if (!rst_n) begin
                s_cnt    = 0;
                i2c_done = 1'b0;
                i2c_nack = 3'b000;
                prev_en  = 1'b0;
                low_cnt  = 0;
            end else begin
                if (i2c_enable && !prev_en) begin
                    if (nwr < 16) wr_data[nwr] = i2c_data;
                    nwr++;
                    if (low_cnt < min_gap) min_gap = low_cnt;
                    cur_data = i2c_data;
                    low_cnt  = 0;
                end else if (i2c_enable && i2c_data !== cur_data) begin
                    stab_err++;
                end
                if (!i2c_enable) low_cnt++;
                if (i2c_done) begin
                    i2c_done = 1'b0;
                    i2c_nack = 3'b000;
                end else if (i2c_enable) begin
                    s_cnt++;
                    if (s_cnt == 3) begin
                        s_cnt    = 0;
                        i2c_done = 1'b1;
                        if (nack_left[rom_index] > 0) begin
                            i2c_nack = 3'(1 << (nack_left[rom_index] % 3));
                            if (nack_left[rom_index] != 255) nack_left[rom_index]--;
                        end
                    end
                end
                prev_en = i2c_enable;
            end
        end
    end

    // seq: nibble k (from LSB) is the table index of the k-th write
    typedef struct packed {
        logic [3:0][15:0] tbl;
        logic [5:0]       nidx;
        logic [7:0]       ncnt;
        logic [4:0]       nw;
        logic [31:0]      seq;
        logic             ed;
        logic             ee;
        logic [5:0]       ei;
        logic [5:0]       ri;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] t0, t1, t2, t3,
                                input int nidx, ncnt, nw, input logic [31:0] seq,
                                input logic ed, ee, input logic [5:0] ei, ri);
        vec_t m;
        m.tbl  = {t3, t2, t1, t0};
        m.nidx = 6'(nidx);
        m.ncnt = 8'(ncnt);
        m.nw   = 5'(nw);
        m.seq  = seq;
        m.ed   = ed;
        m.ee   = ee;
        m.ei   = ei;
        m.ri   = ri;
        return m;
    endfunction

    vec_t vecs [6];

    task automatic load_table(input vec_t v);
        for (int j = 0; j < 64; j++) begin
            rom[j]       = (j < 4) ? v.tbl[j] : 16'hBEEF;
            nack_left[j] = (j == int'(v.nidx)) ? int'(v.ncnt) : 0;
        end
    endtask

    task automatic run_vec(input int i, input int hold, output int lat);
        vec_t v;
        logic [3:0] n;
        v = vecs[i];
        load_table(v);
        @(negedge clk2);
        nwr      = 0;
        min_gap  = 1000;
        stab_err = 0;
        start    = 1'b1;
        lat      = 0;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk2);
            lat = c;
            if (c >= hold) start = 1'b0;
            if (!busy) break;
        end
        start = 1'b0;
        chk($sformatf("v%0d_timeout", i), busy, 1'b0);
        chk($sformatf("v%0d_done", i), done, v.ed);
        chk($sformatf("v%0d_error", i), error, v.ee);
        chk($sformatf("v%0d_err_index", i), err_index, v.ei);
        chk($sformatf("v%0d_rom_index", i), rom_index, v.ri);
        chk($sformatf("v%0d_writes", i), nwr, v.nw);
        for (int k = 0; k < int'(v.nw) && k < 16; k++) begin
            n = v.seq[4*k +: 4];
            chk($sformatf("v%0d_wdata%0d", i, k), wr_data[k], v.tbl[n[1:0]]);
        end
        if (v.nw > 1) chk($sformatf("v%0d_min_gap_ok", i), (min_gap >= 4), 1'b1);
        chk($sformatf("v%0d_data_stable", i), stab_err, 0);
    endtask

    int lat;
    int nwr_snap;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            rom[j]       = 16'hBEEF;
            nack_left[j] = 0;
        end

        vecs[0] = mk(16'h4110, 16'h9803, 16'hFFFF, 16'h0000, 0, 0, 2, 32'h10, 1, 0, 0, 2);
        vecs[3] = mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, 4, 32'h3210, 1, 0, 0, 4);
        vecs[4] = mk(16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 32'h0, 1, 0, 0, 0);
`ifdef HDMI_INIT_RETRY_EN
        vecs[1] = mk(16'h4110, 16'h9803, 16'h1234, 16'hFFFF, 1, 2, 5, 32'h21110, 1, 0, 0, 3);
        vecs[2] = mk(16'hA001, 16'hA002, 16'hA003, 16'hA004, 2, 255, 6, 32'h222210, 0, 1, 2, 2);
        vecs[5] = mk(16'h7E01, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 2, 32'h00, 1, 0, 0, 1);
`else
        vecs[1] = mk(16'h4110, 16'h9803, 16'h1234, 16'hFFFF, 1, 2, 2, 32'h10, 0, 1, 1, 1);
        vecs[2] = mk(16'hA001, 16'hA002, 16'hA003, 16'hA004, 2, 255, 3, 32'h210, 0, 1, 2, 2);
        vecs[5] = mk(16'h7E01, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1, 32'h0, 0, 1, 0, 0);
`endif

        repeat (3) @(negedge clk2);
        chk("rst_enable", i2c_enable, 1'b0);
        chk("rst_data", i2c_data, 16'h0);
        chk("rst_rom_index", rom_index, 6'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_err_index", err_index, 6'd0);
        chk("i2c_addr", i2c_addr, 7'h39);
        @(negedge clk2);
        rst_n = 1'b1;
        repeat (3) @(negedge clk2);
        chk("idle_busy", busy, 1'b0);

        // Start held high while busy: a restart would reload the power-up wait and stretch latency
        for (int i = 0; i < 6; i++) begin
            run_vec(i, (i == 0) ? 15 : 1, lat);
            if (i == 0) chk("v0_latency", lat, 24);
        end

        // Asynchronous reset in the middle of a write
        load_table(vecs[3]);
        @(negedge clk2);
        start = 1'b1;
        @(negedge clk2);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (i2c_enable) break;
            @(negedge clk2);
        end
        chk("midrst_enable_seen", i2c_enable, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_enable", i2c_enable, 1'b0);
        chk("midrst_data", i2c_data, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rom_index", rom_index, 6'd0);
        chk("midrst_done_err", {done, error}, 2'b00);
        @(negedge clk2);
        nwr_snap = nwr;
        rst_n = 1'b1;
        repeat (40) @(negedge clk2);
        chk("postrst_no_write", nwr, nwr_snap);
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_enable", i2c_enable, 1'b0);
        chk("done_error_exclusive", both_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdmi_init_seq.md
HDMI_INIT_SEQ -- requirements
Module: hdmi_init_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, 7-bit I2C slave address driven on i2c_addr.
REQ-002 SHALL have parameter NUM_ENTRIES, default 32, maximum table entries walked (1..64).
REQ-003 SHALL have parameter POWERUP_WAIT, default 1000, clk2 cycles waited after start before the first write.
REQ-004 SHALL have parameter GAP_CYCLES, default 4, clk2 cycles i2c_enable is held low between transactions (minimum 2).
REQ-005 SHALL have parameter MAX_RETRY, default 3, extra attempts per entry after a NACK.
REQ-006 SHALL have ports: clk2 in 1 (sole clock); rst_n in 1 (asynchronous, active-low reset); start in 1 (begin sequence, level sampled each cycle); rom_index out 6 (table entry address); rom_data in 16 (entry {reg,value}, combinational, valid the cycle after rom_index changes); i2c_enable out 1; i2c_addr out 7; i2c_data out 16; i2c_done in 1; i2c_nack in 3; busy out 1; done out 1; error out 1; err_index out 6.

Function
REQ-007 SHALL implement states IDLE, PWR_WAIT, LOAD, WRITE, GAP, DONE, ERROR.
REQ-008 IDLE/DONE/ERROR with start=1 SHALL, next edge: rom_index<=0, retry count<=0, counter<=POWERUP_WAIT, done<=0, error<=0, state<=PWR_WAIT.
REQ-009 start while busy (PWR_WAIT, LOAD, WRITE, GAP) SHALL be ignored.
REQ-010 PWR_WAIT SHALL decrement the counter each cycle and enter LOAD the cycle after it reads 0.
REQ-011 LOAD SHALL take exactly one cycle: if rom_data==16'hFFFF or rom_index==NUM_ENTRIES -> DONE; otherwise i2c_data<=rom_data, i2c_enable<=1, state<=WRITE.
REQ-012 i2c_addr SHALL equal DEV_ADDR constantly.
REQ-013 WRITE SHALL hold i2c_enable=1 and i2c_data stable until i2c_done=1, then drop i2c_enable, load counter with GAP_CYCLES and enter GAP.
REQ-014 On i2c_done, i2c_nack==3'b000 SHALL mark the entry successful; any nonzero bit SHALL mark it failed.
REQ-015 GAP SHALL count GAP_CYCLES cycles with i2c_enable=0, then: success -> rom_index+1, retry count<=0, LOAD; failure with retry count<MAX_RETRY -> retry count+1, i2c_enable<=1, WRITE on the same entry; failure otherwise -> ERROR.
REQ-016 ERROR SHALL set error=1 and err_index=failing rom_index; both hold until restart or reset.
REQ-017 DONE SHALL set done=1, held until restart or reset; done and error SHALL never both be 1.
REQ-018 busy SHALL be 1 exactly in PWR_WAIT, LOAD, WRITE, GAP.
REQ-019 rom_index SHALL never exceed NUM_ENTRIES; an entry at index NUM_ENTRIES SHALL NOT be written.
REQ-020 i2c_enable SHALL be low at least GAP_CYCLES cycles between any two transactions, including retries.

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, i2c_enable 0, i2c_data 0, rom_index 0, err_index 0, busy 0, done 0, error 0, counters 0.
REQ-022 Reset mid-transaction SHALL drop i2c_enable immediately (aborting the I2C write); no write resumes after release until start.

Configuration
REQ-023 With HDMI_INIT_RETRY_EN defined, retry SHALL behave per REQ-015 using MAX_RETRY.
REQ-024 Without HDMI_INIT_RETRY_EN, the first failed entry SHALL go GAP -> ERROR; the retry counter SHALL not exist and MAX_RETRY SHALL be ignored.

Verification
REQ-025 POWERUP_WAIT=5, table {16'h4110, 16'h9803, 16'hFFFF}, ACKing slave model, 1-cycle start -> exactly two i2c_enable pulses, i2c_data 16'h4110 then 16'h9803, done=1, error=0, busy=0.
REQ-026 Slave NACKs entry 1 twice, then ACKs, RETRY_EN defined, MAX_RETRY=3 -> three attempts of entry 1, each preceded by >=GAP_CYCLES low enable cycles, then done=1.
REQ-027 Slave NACKs entry 2 always, RETRY_EN defined, MAX_RETRY=3 -> 4 attempts, error=1, err_index=2, done=0; without RETRY_EN -> 1 attempt, same error outputs.
REQ-028 Table with no 16'hFFFF, NUM_ENTRIES=4 -> exactly 4 writes, done=1, rom_index=4.
REQ-029 rst_n asserted while WRITE with i2c_enable=1 -> i2c_enable 0 same cycle (asynchronous), all outputs at reset values; start held high during busy -> no restart observed.
